// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: FSM state encoding, byte-lane
// identifiers, access-size codes and the byte-offset to lane mapping.
package load_store_unit_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD     = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_RMW_WR = 3'd3,
    ST_WR     = 3'd4,
    ST_RESP   = 3'd5
  } lsu_state_e;

  // Byte lanes of a 32-bit word; lane n occupies bits [8n+7:8n]
  localparam logic [1:0] LANE_0 = 2'd0;
  localparam logic [1:0] LANE_1 = 2'd1;
  localparam logic [1:0] LANE_2 = 2'd2;
  localparam logic [1:0] LANE_3 = 2'd3;

  // Encoding of req_byte
  localparam logic SIZE_BYTE = 1'b1;
  localparam logic SIZE_WORD = 1'b0;

  // Map a byte offset within a word to the bit lane that holds it
  function automatic logic [1:0] lane_of(input logic [1:0] offset, input logic big_endian);
    if (big_endian) begin
      return 2'd3 - offset;
    end else begin
      return offset;
    end
  endfunction

endpackage

// File: rtl/load_store_unit_lane_mux.sv
// Byte-lane steering for the load/store unit (purely combinational).
// Ports:
//   offset    in  2   byte offset within the word (address bits [1:0])
//   word      in  32  word read from memory
//   wbyte     in  8   byte to insert for a byte store
//   load_byte out 32  addressed byte right-aligned, zero-filled
//   merged    out 32  word with the addressed lane replaced by wbyte
module load_store_unit_lane_mux
  import load_store_unit_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  input  logic [7:0]  wbyte,
  output logic [31:0] load_byte,
  output logic [31:0] merged
);

  logic [1:0] lane;

  // Select the lane for extraction and for insertion
  always_comb begin
    lane      = lane_of(offset, BIG_ENDIAN);
    load_byte = 32'h0000_0000;
    merged    = word;
    case (lane)
      LANE_0: begin
        load_byte    = {24'h00_0000, word[7:0]};
        merged[7:0]  = wbyte;
      end
      LANE_1: begin
        load_byte    = {24'h00_0000, word[15:8]};
        merged[15:8] = wbyte;
      end
      LANE_2: begin
        load_byte     = {24'h00_0000, word[23:16]};
        merged[23:16] = wbyte;
      end
      LANE_3: begin
        load_byte     = {24'h00_0000, word[31:24]};
        merged[31:24] = wbyte;
      end
      default: begin
        load_byte = 32'h0000_0000;
        merged    = word;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: sequences LB/LW/SB/SW from the MEM stage onto a word-wide
// data-memory port with a ready handshake. Byte stores use read-modify-write.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake (ready only when idle)
//   req_we, req_byte         store/load, byte/word
//   req_addr, req_wdata      byte address, store data (byte store uses [7:0])
//   rsp_valid                one-cycle completion pulse
//   rsp_err, rsp_rdata       error flag and load data, held between pulses
//   mem_en, mem_we           memory request and write strobe
//   mem_addr, mem_wdata      word address and write data
//   mem_rdata, mem_ready     read data and completion from memory
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int MEM_AW     = 14,
  parameter bit BIG_ENDIAN = 1'b1,
  parameter int TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_byte,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [31:0]       rsp_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready
);

  localparam int          CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit          TO_EN    = (TIMEOUT != 0);
  localparam logic [CW-1:0] WAIT_MAX = CW'(TIMEOUT);

  lsu_state_e    state;
  lsu_state_e    next_state;
  logic          byte_r;
  logic [1:0]    off_r;
  logic [7:0]    wbyte_r;
  logic [CW-1:0] wait_cnt;
  logic [CW-1:0] wait_nxt;
  logic          in_mem;
  logic          timed_out;
  logic          accept;
  logic          resp_err_n;
  logic [31:0]   resp_data_n;
  logic [31:0]   load_byte;
  logic [31:0]   merged_word;

  // Address bits above the memory size are deliberately dropped
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:MEM_AW+2];

  assign accept = req_valid && req_ready;

  load_store_unit_lane_mux #(
    .BIG_ENDIAN(BIG_ENDIAN)
  ) u_lane_mux (
    .offset   (off_r),
    .word     (mem_rdata),
    .wbyte    (wbyte_r),
    .load_byte(load_byte),
    .merged   (merged_word)
  );

  // Next-state, wait-counter update and response value selection
  always_comb begin
    next_state  = state;
    resp_err_n  = 1'b0;
    resp_data_n = 32'h0000_0000;
    in_mem      = (state == ST_RD) || (state == ST_RMW_RD) ||
                  (state == ST_RMW_WR) || (state == ST_WR);
    // Saturating count of stalled cycles in the current memory state
    if (in_mem && !mem_ready && (wait_cnt != WAIT_MAX)) begin
      wait_nxt = wait_cnt + CW'(1);
    end else begin
      wait_nxt = wait_cnt;
    end
    // A completing handshake takes priority over an expiring timeout
    timed_out = TO_EN && in_mem && !mem_ready && (wait_nxt == WAIT_MAX);

    case (state)
      ST_IDLE: begin
        if (accept) begin
          if ((req_byte == SIZE_WORD) && (req_addr[1:0] != 2'b00)) begin
            next_state = ST_RESP;
            resp_err_n = 1'b1;
          end else if (!req_we) begin
            next_state = ST_RD;
          end else if (req_byte == SIZE_BYTE) begin
            next_state = ST_RMW_RD;
          end else begin
            next_state = ST_WR;
          end
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_RD: begin
        if (mem_ready) begin
          next_state  = ST_RESP;
          resp_data_n = byte_r ? load_byte : mem_rdata;
        end else if (timed_out) begin
          next_state = ST_RESP;
          resp_err_n = 1'b1;
        end else begin
          next_state = ST_RD;
        end
      end
      ST_RMW_RD: begin
        if (mem_ready) begin
          next_state = ST_RMW_WR;
        end else if (timed_out) begin
          next_state = ST_RESP;
          resp_err_n = 1'b1;
        end else begin
          next_state = ST_RMW_RD;
        end
      end
      ST_WR, ST_RMW_WR: begin
        if (mem_ready) begin
          next_state = ST_RESP;
        end else if (timed_out) begin
          next_state = ST_RESP;
          resp_err_n = 1'b1;
        end else begin
          next_state = state;
        end
      end
      ST_RESP: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // State, request capture, wait counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      byte_r    <= 1'b0;
      off_r     <= 2'b00;
      wbyte_r   <= 8'h00;
      wait_cnt  <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'h0000_0000;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'h0000_0000;
    end else begin
      state     <= next_state;
      req_ready <= (next_state == ST_IDLE);
      rsp_valid <= (next_state == ST_RESP);
      mem_en    <= (next_state == ST_RD) || (next_state == ST_RMW_RD) ||
                   (next_state == ST_RMW_WR) || (next_state == ST_WR);
      mem_we    <= (next_state == ST_RMW_WR) || (next_state == ST_WR);
      if (accept) begin
        byte_r    <= req_byte;
        off_r     <= req_addr[1:0];
        wbyte_r   <= req_wdata[7:0];
        mem_addr  <= req_addr[MEM_AW+1:2];
        mem_wdata <= req_wdata;
      end else if ((state == ST_RMW_RD) && mem_ready) begin
        mem_wdata <= merged_word;
      end
      if ((next_state == ST_RESP) && (state != ST_RESP)) begin
        rsp_err   <= resp_err_n;
        rsp_rdata <= resp_data_n;
      end
      // Restart the count whenever a new state is entered
      if (next_state != state) begin
        wait_cnt <= '0;
      end else begin
        wait_cnt <= wait_nxt;
      end
    end
  end

endmodule
